// File: rtl/display_scan_if.sv
// Bus bundle between a host and the display_scan controller.
// Input names keep the i/o prefixes the board-level netlist expects.
interface display_scan_if;
    logic [31:0] iData;
    logic        iLoad;
    logic        iEn;
    logic        iLzb;
    logic [7:0]  oSel;
    logic [6:0]  oSeg;
    logic        oPending;
    logic        oFrame;

    // Host side: supplies value/control, observes the scan outputs.
    modport master (
        output iData, iLoad, iEn, iLzb,
        input  oSel, oSeg, oPending, oFrame
    );

    // Controller side.
    modport slave (
        input  iData, iLoad, iEn, iLzb,
        output oSel, oSeg, oPending, oFrame
    );
endinterface

// File: rtl/display_scan.sv
// Eight-digit seven-segment scan controller with a double-buffered value.
// A shadow register takes host loads; the display register is refreshed
// only when digit 7 is driven, so a frame never mixes old and new digits.

// Hex nibble to active-low segment code, bit order {g,f,e,d,c,b,a}.
module display7 (
    input  logic [3:0] iData,
    output logic [6:0] oData
);
    // Pure lookup, one code per hex value.
    always_comb begin
        oData = 7'b1111111;
        case (iData)
            4'h0: oData = 7'b1000000;
            4'h1: oData = 7'b1111001;
            4'h2: oData = 7'b0100100;
            4'h3: oData = 7'b0110000;
            4'h4: oData = 7'b0011001;
            4'h5: oData = 7'b0010010;
            4'h6: oData = 7'b0000010;
            4'h7: oData = 7'b1111000;
            4'h8: oData = 7'b0000000;
            4'h9: oData = 7'b0010000;
            4'hA: oData = 7'b0001000;
            4'hB: oData = 7'b0000011;
            4'hC: oData = 7'b1000110;
            4'hD: oData = 7'b0100001;
            4'hE: oData = 7'b0000110;
            4'hF: oData = 7'b0001110;
            default: oData = 7'b1111111;
        endcase
    end
endmodule

module display_scan #(
    parameter int         DIV   = 50000,
    parameter logic [6:0] BLANK = 7'b1111111
) (
    input  logic          iClk,
    input  logic          iRst_n,
    display_scan_if.slave bus
);
    // Prescaler needs at least one bit even when DIV is 1.
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [31:0]   shadow;
    logic [31:0]   disp;
    logic [7:0]    sel;
    logic [6:0]    seg;
    logic          pending;
    logic          frame;

    logic          tick;
    logic          commit;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic [7:0]    blank;

    // A slot ends when the prescaler reaches its last count while enabled;
    // the slot that drives digit 7 is also the frame boundary.
    assign tick   = bus.iEn && (pcnt == PMAX);
    assign commit = tick && (idx == 3'd7);

    // Single shared decoder fed with the nibble of the digit about to be shown.
    assign nib = disp[{idx, 2'b00} +: 4];

    display7 u_display7 (
        .iData (nib),
        .oData (dec)
    );

    // Leading-zero mask: walking down from digit 7, a digit stays blank
    // while it and every digit above it are zero. Digit 0 always shows.
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int k = 7; k >= 1; k--) begin
            run      = run && (disp[4*k +: 4] == 4'h0);
            blank[k] = run && bus.iLzb;
        end
    end

    // Prescaler and digit pointer; both freeze at a known point while disabled.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pcnt <= '0;
            idx  <= 3'd0;
        end else if (!bus.iEn) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + 3'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Select and segment code are registered together so they always switch
    // on the same edge; disabled scan drives every digit off.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sel <= 8'hFF;
            seg <= BLANK;
        end else if (!bus.iEn) begin
            sel <= 8'hFF;
            seg <= BLANK;
        end else if (tick) begin
            sel <= ~(8'b1 << idx);
            seg <= blank[idx] ? BLANK : dec;
        end
    end

    // Double buffer: loads land in shadow; disp is swapped at the commit.
    // A load on the commit edge bypasses shadow so it is not lost a frame.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (bus.iLoad) begin
                shadow <= bus.iData;
            end
            if (commit) begin
                disp    <= bus.iLoad ? bus.iData : shadow;
                pending <= 1'b0;
            end else if (bus.iLoad) begin
                pending <= 1'b1;
            end
        end
    end

    // Frame strobe lines up with the edge that drives digit 7.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            frame <= 1'b0;
        end else begin
            frame <= commit;
        end
    end

    assign bus.oSel     = sel;
    assign bus.oSeg     = seg;
    assign bus.oPending = pending;
    assign bus.oFrame   = frame;
endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIV=4 (one slot = 4 clocks, frame = 32).
// Edge numbering restarts at each reset release: edge 1 is the first rising
// edge after iRst_n goes high. Outputs are sampled on the falling edge.
module tb_display_scan;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    display_scan_if bus ();

    display_scan #(.DIV(4), .BLANK(7'b1111111)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Advance n rising edges, ending on a falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reset pulse ending on a falling edge; next rising edge is edge 1.
    task automatic do_reset(input logic en);
        @(negedge clk);
        rst_n     = 1'b0;
        bus.iEn   = en;
        bus.iLoad = 1'b0;
        bus.iLzb  = 1'b0;
        bus.iData = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Load at the next edge.
    task automatic load1(input logic [31:0] d);
        bus.iLoad = 1'b1;
        bus.iData = d;
        step(1);
        bus.iLoad = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        bus.iEn = 1'b1;
        bus.iLoad = 1'b0;
        bus.iLzb = 1'b0;
        bus.iData = 32'h0;
        @(negedge clk);
        n_cmp++; if (bus.oSel !== 8'hFF) begin n_fail++; $display("FAIL reset_sel got %h exp %h", bus.oSel, 8'hFF); end
        n_cmp++; if (bus.oSeg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h exp %h", bus.oSeg, 7'h7F); end
        n_cmp++; if (bus.oPending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", bus.oPending); end
        n_cmp++; if (bus.oFrame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b exp 0", bus.oFrame); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_frame;
        step(1);                     // edge 1
        load1(32'h76543210);         // captured at edge 2
        n_cmp++; if (bus.oPending !== 1'b1) begin n_fail++; $display("FAIL ff_pending got %b exp 1", bus.oPending); end
        step(1);                     // edge 3
        n_cmp++; if (bus.oSel !== 8'hFF) begin n_fail++; $display("FAIL ff_sel_e3 got %h exp FF", bus.oSel); end
        n_cmp++; if (bus.oSeg !== 7'h7F) begin n_fail++; $display("FAIL ff_seg_e3 got %h exp 7F", bus.oSeg); end
        step(1);                     // edge 4
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.oSel !== ~(8'h01 << k)) begin n_fail++; $display("FAIL f1_sel d%0d got %h exp %h", k, bus.oSel, ~(8'h01 << k)); end
            n_cmp++; if (bus.oSeg !== seg7(4'h0)) begin n_fail++; $display("FAIL f1_seg d%0d got %h exp %h", k, bus.oSeg, seg7(4'h0)); end
            if (k == 7) begin
                n_cmp++; if (bus.oFrame !== 1'b1) begin n_fail++; $display("FAIL f1_frame got %b exp 1", bus.oFrame); end
                n_cmp++; if (bus.oPending !== 1'b0) begin n_fail++; $display("FAIL f1_pending got %b exp 0", bus.oPending); end
            end else begin
                n_cmp++; if (bus.oFrame !== 1'b0) begin n_fail++; $display("FAIL f1_frame_low d%0d got %b exp 0", k, bus.oFrame); end
            end
            step(3);
            n_cmp++; if (bus.oSel !== ~(8'h01 << k)) begin n_fail++; $display("FAIL f1_hold d%0d got %h exp %h", k, bus.oSel, ~(8'h01 << k)); end
            step(1);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.oSel !== ~(8'h01 << k)) begin n_fail++; $display("FAIL f2_sel d%0d got %h exp %h", k, bus.oSel, ~(8'h01 << k)); end
            n_cmp++; if (bus.oSeg !== seg7(4'(k))) begin n_fail++; $display("FAIL f2_seg d%0d got %h exp %h", k, bus.oSeg, seg7(4'(k))); end
            if (k == 7) begin
                n_cmp++; if (bus.oFrame !== 1'b1) begin n_fail++; $display("FAIL f2_frame got %b exp 1", bus.oFrame); end
            end
            step(4);
        end
    endtask

    task automatic test_double_load;
        do_reset(1'b1);
        step(5);                      // edge 5
        load1(32'h11111111);          // edge 6
        n_cmp++; if (bus.oPending !== 1'b1) begin n_fail++; $display("FAIL dl_pending1 got %b exp 1", bus.oPending); end
        step(8);                      // edge 14
        load1(32'h22222222);          // edge 15
        step(16);                     // edge 31
        n_cmp++; if (bus.oPending !== 1'b1) begin n_fail++; $display("FAIL dl_pending31 got %b exp 1", bus.oPending); end
        step(1);                      // edge 32
        n_cmp++; if (bus.oPending !== 1'b0) begin n_fail++; $display("FAIL dl_pending32 got %b exp 0", bus.oPending); end
        n_cmp++; if (bus.oFrame !== 1'b1) begin n_fail++; $display("FAIL dl_frame got %b exp 1", bus.oFrame); end
        step(4);                      // edge 36
        n_cmp++; if (bus.oSel !== 8'hFE) begin n_fail++; $display("FAIL dl_sel got %h exp FE", bus.oSel); end
        n_cmp++; if (bus.oSeg !== seg7(4'h2)) begin n_fail++; $display("FAIL dl_seg got %h exp %h", bus.oSeg, seg7(4'h2)); end
    endtask

    task automatic test_load_on_commit;
        do_reset(1'b1);
        step(31);                     // edge 31
        load1(32'hAAAAAAAA);          // edge 32 = commit
        n_cmp++; if (bus.oPending !== 1'b0) begin n_fail++; $display("FAIL lc_pending got %b exp 0", bus.oPending); end
        n_cmp++; if (bus.oFrame !== 1'b1) begin n_fail++; $display("FAIL lc_frame got %b exp 1", bus.oFrame); end
        n_cmp++; if (bus.oSeg !== seg7(4'h0)) begin n_fail++; $display("FAIL lc_d7_old got %h exp %h", bus.oSeg, seg7(4'h0)); end
        step(4);                      // edge 36
        n_cmp++; if (bus.oSel !== 8'hFE) begin n_fail++; $display("FAIL lc_sel got %h exp FE", bus.oSel); end
        n_cmp++; if (bus.oSeg !== seg7(4'hA)) begin n_fail++; $display("FAIL lc_seg got %h exp %h", bus.oSeg, seg7(4'hA)); end
        n_cmp++; if (bus.oPending !== 1'b0) begin n_fail++; $display("FAIL lc_pending36 got %b exp 0", bus.oPending); end
    endtask

    task automatic test_lzb;
        logic [6:0] exp_f2 [8];
        exp_f2[0] = seg7(4'h5);
        exp_f2[1] = seg7(4'h0);
        exp_f2[2] = seg7(4'h3);
        for (int k = 3; k < 8; k++) exp_f2[k] = 7'h7F;
        do_reset(1'b1);
        bus.iLzb = 1'b1;
        load1(32'h00000305);          // edge 1
        step(3);                      // edge 4: disp still 0
        n_cmp++; if (bus.oSeg !== seg7(4'h0)) begin n_fail++; $display("FAIL lzb_zero_d0 got %h exp %h", bus.oSeg, seg7(4'h0)); end
        step(4);                      // edge 8
        n_cmp++; if (bus.oSeg !== 7'h7F) begin n_fail++; $display("FAIL lzb_zero_d1 got %h exp 7F", bus.oSeg); end
        step(28);                     // edge 36
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.oSel !== ~(8'h01 << k)) begin n_fail++; $display("FAIL lzb_sel d%0d got %h exp %h", k, bus.oSel, ~(8'h01 << k)); end
            n_cmp++; if (bus.oSeg !== exp_f2[k]) begin n_fail++; $display("FAIL lzb_seg d%0d got %h exp %h", k, bus.oSeg, exp_f2[k]); end
            if (k == 2) begin
                load1(32'h00000000);
                step(3);
            end else begin
                step(4);
            end
        end
        for (int k = 0; k < 8; k++) begin     // edges 68..96
            n_cmp++; if (bus.oSeg !== ((k == 0) ? seg7(4'h0) : 7'h7F)) begin n_fail++; $display("FAIL lzb0_seg d%0d got %h exp %h", k, bus.oSeg, (k == 0) ? seg7(4'h0) : 7'h7F); end
            step(4);
        end
        bus.iLzb = 1'b0;
    endtask

    task automatic test_enable_gating;
        do_reset(1'b1);
        load1(32'h76543210);          // edge 1
        step(47);                     // edge 48: digit 3 of frame 2
        n_cmp++; if (bus.oSel !== 8'hF7) begin n_fail++; $display("FAIL en_sel_d3 got %h exp F7", bus.oSel); end
        n_cmp++; if (bus.oSeg !== seg7(4'h3)) begin n_fail++; $display("FAIL en_seg_d3 got %h exp %h", bus.oSeg, seg7(4'h3)); end
        bus.iEn = 1'b0;
        step(1);                      // edge 49
        n_cmp++; if (bus.oSel !== 8'hFF) begin n_fail++; $display("FAIL en_off_sel got %h exp FF", bus.oSel); end
        n_cmp++; if (bus.oSeg !== 7'h7F) begin n_fail++; $display("FAIL en_off_seg got %h exp 7F", bus.oSeg); end
        load1(32'h89ABCDEF);          // edge 50
        step(5);                      // edge 55
        n_cmp++; if (bus.oPending !== 1'b1) begin n_fail++; $display("FAIL en_pending got %b exp 1", bus.oPending); end
        n_cmp++; if (bus.oFrame !== 1'b0) begin n_fail++; $display("FAIL en_frame got %b exp 0", bus.oFrame); end
        bus.iEn = 1'b1;
        step(3);                      // edge 58
        n_cmp++; if (bus.oSel !== 8'hFF) begin n_fail++; $display("FAIL en_re3_sel got %h exp FF", bus.oSel); end
        step(1);                      // edge 59
        n_cmp++; if (bus.oSel !== 8'hEF) begin n_fail++; $display("FAIL en_re4_sel got %h exp EF", bus.oSel); end
        n_cmp++; if (bus.oSeg !== seg7(4'h4)) begin n_fail++; $display("FAIL en_re4_seg got %h exp %h", bus.oSeg, seg7(4'h4)); end
        n_cmp++; if (bus.oPending !== 1'b1) begin n_fail++; $display("FAIL en_re_pending got %b exp 1", bus.oPending); end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1);
        load1(32'h76543210);          // edge 1
        step(49);                     // edge 50
        load1(32'h12345678);          // edge 51
        step(5);                      // edge 56: digit 5
        n_cmp++; if (bus.oSel !== 8'hDF) begin n_fail++; $display("FAIL ar_sel_d5 got %h exp DF", bus.oSel); end
        n_cmp++; if (bus.oSeg !== seg7(4'h5)) begin n_fail++; $display("FAIL ar_seg_d5 got %h exp %h", bus.oSeg, seg7(4'h5)); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.oSel !== 8'hFF) begin n_fail++; $display("FAIL ar_sel got %h exp FF", bus.oSel); end
        n_cmp++; if (bus.oSeg !== 7'h7F) begin n_fail++; $display("FAIL ar_seg got %h exp 7F", bus.oSeg); end
        n_cmp++; if (bus.oPending !== 1'b0) begin n_fail++; $display("FAIL ar_pending got %b exp 0", bus.oPending); end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        n_cmp++; if (bus.oSel !== 8'hFF) begin n_fail++; $display("FAIL ar_e3_sel got %h exp FF", bus.oSel); end
        step(1);
        n_cmp++; if (bus.oSel !== 8'hFE) begin n_fail++; $display("FAIL ar_e4_sel got %h exp FE", bus.oSel); end
        n_cmp++; if (bus.oSeg !== seg7(4'h0)) begin n_fail++; $display("FAIL ar_e4_seg got %h exp %h", bus.oSeg, seg7(4'h0)); end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        bus.iEn   = 1'b0;
        bus.iLoad = 1'b0;
        bus.iLzb  = 1'b0;
        bus.iData = 32'h0;
        test_reset();
        test_first_frame();
        test_double_load();
        test_load_on_commit();
        test_lzb();
        test_enable_gating();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan controller for the 8-digit seven-segment display. Holds a 32-bit value of eight hex nibbles and cycles the digit enables at a programmable rate. It drives one shared `display7` decoder instance (4-bit `iData` to 7-bit `oData`) with the nibble of the active digit. Loads are double-buffered and committed only at frame boundaries so the display never shows a mix of old and new values.

## Interface
- `DIV`, 50000: clock cycles per digit slot. Legal range is 1 or more. Prescaler width is `$clog2(DIV)`, minimum 1.
- `BLANK`, 7'b1111111: segment code driven for a blanked or disabled digit. The board segments are active-low.
- `iClk` in 1: system clock. All state updates on the rising edge.
- `iRst_n` in 1: asynchronous, active-low reset.
- `iData` in 32: display value. Nibble k (`iData[4k+3:4k]`) is digit k. Digit 0 is rightmost.
- `iLoad` in 1: when high at a rising edge, capture `iData` into the shadow register.
- `iEn` in 1: scan enable.
- `iLzb` in 1: leading-zero blanking enable.
- `oSel` out 8: digit enables, active-low, one-cold.
- `oSeg` out 7: segment code for the digit selected by `oSel`.
- `oPending` out 1: shadow holds data not yet committed.
- `oFrame` out 1: one-cycle pulse at each frame commit point.

## Operation
- **Registers:**
  - `pcnt`: prescaler.
  - `idx[2:0]`: next digit to show.
  - `shadow[31:0]`, `disp[31:0]`: shadow and display registers.
  - `oSel`, `oSeg`, `oPending`, `oFrame`: all outputs are registered.
- **Tick:** `tick` = `iEn` and (`pcnt == DIV-1`). `pcnt` wraps to 0 on tick and otherwise increments while `iEn` is high.
- **On tick:**
  - `oSel` <= ~(8'b1 << `idx`).
  - `oSeg` <= `BLANK` if digit `idx` is blanked, else the `display7` decode of `disp[4*idx+3 -: 4]`.
  - `idx` <= `idx`+1, wrapping 7 to 0.
- **Commit point:** the tick with `idx == 7`. On that same edge:
  - `disp` <= `shadow`. Digit 7 is driven from the old `disp`.
  - `oPending` <= 0.
  - `oFrame` <= 1.
  - `oFrame` is 0 on every other edge.
- **Load:** `iLoad` high sets `shadow` <= `iData` and `oPending` <= 1. Repeated loads before a commit: the last one wins.
- **Load and commit on the same edge:** `disp` <= `iData` directly, `shadow` <= `iData`, `oPending` <= 0.
- **Leading-zero blanking:** with `iLzb` high, digit k (k = 7..1) is blanked when `disp` nibbles k..7 are all zero. Digit 0 is never blanked. Example: `disp` = 0 shows a single "0".
- **`iEn` low:**
  - `pcnt` <= 0 and `idx` holds.
  - `oSel` <= 8'hFF, `oSeg` <= `BLANK`, `oFrame` <= 0.
  - Loads are still accepted. No commit occurs, so `oPending` stays high.
  - On re-enable, the first tick comes after `DIV` cycles and shows digit `idx`.
- **`display7`:** instantiated once, combinational. Its input is muxed from `disp` by `idx`.

## Timing
- **Reset values:** `pcnt`=0, `idx`=0, `shadow`=0, `disp`=0, `oSel`=8'hFF, `oSeg`=`BLANK`, `oPending`=0, `oFrame`=0. Reset is asynchronous and may be asserted mid-frame: everything returns to these values at once.
- **First tick:** at the `DIV`-th rising edge after `iRst_n` deasserts with `iEn` high. It shows digit 0.
- **Slot rate:** each digit is held for exactly `DIV` cycles. A full frame is 8·`DIV` cycles.
- **`DIV` = 1:** tick on every enabled cycle. The digit changes every clock and a commit occurs every 8 cycles.
- **Load-to-visible latency:** at most 8·`DIV`+`DIV` cycles (commit wait plus the digit 0 slot). At least 1 cycle after the commit edge.
- **Output alignment:** `oSel` and `oSeg` always change on the same edge. No cycle ever pairs a new select with an old segment code.
- **`oFrame`:** coincides with the edge that drives digit 7.

## Test plan
1. **Reset and first frame:** `DIV`=4, `iEn`=1, load 32'h76543210.
   - After reset: `oSel`=FF and `oSeg`=7F until edge 4.
   - Then `oSel` steps FE, FD, … 7F, each for 4 cycles, with `oSeg` = decode of 0..7.
   - Load at cycle 2: digits show 0 until the first commit. `oFrame` pulses at edge 32. The second frame shows 0..7.
2. **Double load before commit:** load 32'h11111111, then 32'h22222222 mid-frame. Only 2 appears after the commit. `oPending` is 1 from the first load until the commit edge.
3. **Load on the commit edge:** assert `iLoad` with 32'hAAAAAAAA on exactly the `idx`=7 tick. The next digit 0 shows A and `oPending` stays 0.
4. **Leading-zero blanking:** `iLzb`=1, commit 32'h00000305. Digits 7..3 show `BLANK`. Digit 2 shows 3, digit 1 shows 0, digit 0 shows 5. Commit 0: only digit 0 shows 0.
5. **Enable gating:**
   - Drop `iEn` while digit 3 is shown: next edge `oSel`=FF and `oSeg`=`BLANK`.
   - A load during `iEn` low keeps `oPending`=1.
   - Re-enable: after 4 cycles digit 4 is shown.
6. **Asynchronous reset mid-frame:** pull `iRst_n` low between clock edges during digit 5. Outputs go to their reset values immediately, with no clock edge needed. After release, the first tick shows digit 0 with `disp`=0.
